// File: rtl/alu_pkg.sv
// Shared definitions for the project-1 datapath: the ALU, the instruction
// decoder and the alu_seq_ctrl sequencer all import this package.
//   N          default datapath width
//   SUMA..     2-bit ALU control codes
//   OP_*       3-bit command op codes seen by the sequencer
//   state_t    sequencer FSM states
//   op_to_ctrl maps a single-cycle op onto its ALU control code
package alu_pkg;

   localparam int N = 16;

   localparam logic [1:0] SUMA    = 2'b00;
   localparam logic [1:0] RESTA   = 2'b10;
   localparam logic [1:0] SHIFT_D = 2'b01;
   localparam logic [1:0] SHIFT_I = 2'b11;   // ALU passes operand a through

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SHR1 = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_PASS = 3'b011;
   localparam logic [2:0] OP_MUL  = 3'b100;
   localparam logic [2:0] OP_SHRN = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      EXEC,
      MUL_STEP,
      SHR_STEP,
      DONE
   } state_t;

   function automatic logic [1:0] op_to_ctrl(input logic [2:0] op);
      logic [1:0] ctrl;
      case (op)
         OP_SUB:  ctrl = RESTA;
         OP_SHR1: ctrl = SHIFT_D;
         OP_PASS: ctrl = SHIFT_I;
         default: ctrl = SUMA;
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Bundle between the command side, the sequencer and the datapath ALU.
//   i_start/i_op/i_a/i_b         command from the decoder
//   o_alu_a/o_alu_b/o_alu_control operands and control towards the ALU
//   i_alu_q/i_alu_mayor/i_alu_paridad  combinational ALU results
//   o_busy/o_done/o_q/o_mayor/o_paridad/o_err  status and result
// Modports: slave = the sequencer, master = decoder + ALU side.
interface alu_seq_ctrl_if #(parameter int N = alu_pkg::N);

   logic         i_start;
   logic [2:0]   i_op;
   logic [N-1:0] i_a;
   logic [N-1:0] i_b;
   logic [N-1:0] o_alu_a;
   logic [N-1:0] o_alu_b;
   logic [1:0]   o_alu_control;
   logic [N-1:0] i_alu_q;
   logic         i_alu_mayor;
   logic         i_alu_paridad;
   logic         o_busy;
   logic         o_done;
   logic [N-1:0] o_q;
   logic         o_mayor;
   logic         o_paridad;
   logic         o_err;

   modport slave (
      input  i_start, i_op, i_a, i_b, i_alu_q, i_alu_mayor, i_alu_paridad,
      output o_alu_a, o_alu_b, o_alu_control,
      output o_busy, o_done, o_q, o_mayor, o_paridad, o_err
   );

   modport master (
      output i_start, i_op, i_a, i_b, i_alu_q, i_alu_mayor, i_alu_paridad,
      input  o_alu_a, o_alu_b, o_alu_control,
      input  o_busy, o_done, o_q, o_mayor, o_paridad, o_err
   );

endinterface

// File: rtl/alu.sv
// Combinational 16-bit datapath ALU driven by alu_seq_ctrl.
//   a, b     operands
//   control  00 add, 10 sub, 01 shift right by one, 11 pass a
//   q        result
//   mayor    carry out of add, borrow of sub, 0 otherwise
//   paridad  q[0]
module alu #(
   parameter int N = alu_pkg::N
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [1:0]   control,
   output logic [N-1:0] q,
   output logic         mayor,
   output logic         paridad
);
   import alu_pkg::*;

   logic [N:0] wide;

   always_comb begin
      wide = '0;
      case (control)
         SUMA:    wide = {1'b0, a} + {1'b0, b};
         RESTA:   wide = {1'b0, a} - {1'b0, b};
         SHIFT_D: wide = {1'b0, 1'b0, a[N-1:1]};
         default: wide = {1'b0, a};
      endcase
   end

   assign q       = wide[N-1:0];
   assign mayor   = wide[N];
   assign paridad = wide[0];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Command sequencer in front of the datapath ALU. Single-cycle ops are
// issued once; MUL (shift-and-add) and SHRN (repeated shift by one) iterate
// the ALU, feeding its combinational result back through the registered
// operand outputs.
//   i_clk, i_reset   clock, synchronous active-high reset
//   bus (slave)      command, ALU interface and result/status
// Build option: define ALU_SEQ_CTRL_MUL_EN to build the multiplier; without
// it op 100 is answered as an illegal op.
module alu_seq_ctrl #(
   parameter int N  = alu_pkg::N,
   parameter int CW = $clog2(N)
) (
   input  logic          i_clk,
   input  logic          i_reset,
   alu_seq_ctrl_if.slave bus
);
   import alu_pkg::*;

   state_t       state_reg, state_next;
   logic [2:0]   op_reg, op_next;
   // During MUL the operand registers double as acc (a) and mcand (b).
   logic [N-1:0] alu_a_reg, alu_a_next;
   logic [N-1:0] alu_b_reg, alu_b_next;
   logic [1:0]   alu_ctrl_reg, alu_ctrl_next;
   logic [CW-1:0] shr_cnt_reg, shr_cnt_next;
   logic [N-1:0] q_reg, q_next;
   logic         mayor_reg, mayor_next;
   logic         paridad_reg, paridad_next;
   logic         err_reg, err_next;
   logic         done_reg, done_next;
   logic         busy_reg, busy_next;
`ifdef ALU_SEQ_CTRL_MUL_EN
   logic [N-1:0]  mplier_reg, mplier_next;
   logic [CW-1:0] mul_cnt_reg, mul_cnt_next;
   logic          ovf_reg, ovf_next;
   logic [N-1:0]  acc_new;
   logic          ovf_new;
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   always_comb begin
      state_next    = state_reg;
      op_next       = op_reg;
      alu_a_next    = alu_a_reg;
      alu_b_next    = alu_b_reg;
      alu_ctrl_next = alu_ctrl_reg;
      shr_cnt_next  = shr_cnt_reg;
      q_next        = q_reg;
      mayor_next    = mayor_reg;
      paridad_next  = paridad_reg;
      err_next      = err_reg;
`ifdef ALU_SEQ_CTRL_MUL_EN
      mplier_next   = mplier_reg;
      mul_cnt_next  = mul_cnt_reg;
      ovf_next      = ovf_reg;
      acc_new       = mplier_reg[0] ? bus.i_alu_q : alu_a_reg;
      ovf_new       = ovf_reg | (mplier_reg[0] & bus.i_alu_mayor)
                    | (alu_b_reg[N-1] & ((mplier_reg >> 1) != '0));
`endif
      case (state_reg)
         IDLE: begin
            if (bus.i_start) begin
               op_next    = bus.i_op;
               err_next   = 1'b0;
               alu_a_next = bus.i_a;
               alu_b_next = bus.i_b;
               case (bus.i_op)
                  OP_ADD, OP_SUB, OP_SHR1, OP_PASS: begin
                     alu_ctrl_next = op_to_ctrl(bus.i_op);
                     state_next    = EXEC;
                  end
`ifdef ALU_SEQ_CTRL_MUL_EN
                  OP_MUL: begin
                     alu_a_next    = '0;
                     alu_b_next    = bus.i_a;
                     alu_ctrl_next = SUMA;
                     mplier_next   = bus.i_b;
                     mul_cnt_next  = '0;
                     ovf_next      = 1'b0;
                     state_next    = MUL_STEP;
                  end
`endif
                  OP_SHRN: begin
                     // k=0 becomes a single pass-through step so both cases
                     // share the same "capture when count reaches 1" exit.
                     if (bus.i_b[CW-1:0] == '0) begin
                        alu_ctrl_next = SHIFT_I;
                        shr_cnt_next  = CW'(1);
                     end else begin
                        alu_ctrl_next = SHIFT_D;
                        shr_cnt_next  = bus.i_b[CW-1:0];
                     end
                     state_next = SHR_STEP;
                  end
                  default: begin
                     err_next     = 1'b1;
                     q_next       = '0;
                     mayor_next   = 1'b0;
                     paridad_next = 1'b0;
                     state_next   = DONE;
                  end
               endcase
            end
         end
         EXEC: begin
            q_next       = bus.i_alu_q;
            paridad_next = bus.i_alu_paridad;
            mayor_next   = (op_reg == OP_ADD) & bus.i_alu_mayor;
            state_next   = DONE;
         end
`ifdef ALU_SEQ_CTRL_MUL_EN
         MUL_STEP: begin
            alu_a_next   = acc_new;
            alu_b_next   = alu_b_reg << 1;
            mplier_next  = mplier_reg >> 1;
            mul_cnt_next = mul_cnt_reg + CW'(1);
            ovf_next     = ovf_new;
            if (((mplier_reg >> 1) == '0) || (mul_cnt_reg == CW'(N-1))) begin
               q_next       = acc_new;
               mayor_next   = ovf_new;
               paridad_next = acc_new[0];
               state_next   = DONE;
            end
         end
`endif
         SHR_STEP: begin
            if (shr_cnt_reg == CW'(1)) begin
               q_next       = bus.i_alu_q;
               paridad_next = bus.i_alu_paridad;
               mayor_next   = 1'b0;
               state_next   = DONE;
            end else begin
               alu_a_next   = bus.i_alu_q;
               shr_cnt_next = shr_cnt_reg - CW'(1);
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // Status flags are registered copies of the state being entered.
      done_next = (state_next == DONE);
      busy_next = (state_next != IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         op_reg       <= '0;
         alu_a_reg    <= '0;
         alu_b_reg    <= '0;
         alu_ctrl_reg <= SUMA;
         shr_cnt_reg  <= '0;
         q_reg        <= '0;
         mayor_reg    <= 1'b0;
         paridad_reg  <= 1'b0;
         err_reg      <= 1'b0;
         done_reg     <= 1'b0;
         busy_reg     <= 1'b0;
`ifdef ALU_SEQ_CTRL_MUL_EN
         mplier_reg   <= '0;
         mul_cnt_reg  <= '0;
         ovf_reg      <= 1'b0;
`endif
      end else begin
         op_reg       <= op_next;
         alu_a_reg    <= alu_a_next;
         alu_b_reg    <= alu_b_next;
         alu_ctrl_reg <= alu_ctrl_next;
         shr_cnt_reg  <= shr_cnt_next;
         q_reg        <= q_next;
         mayor_reg    <= mayor_next;
         paridad_reg  <= paridad_next;
         err_reg      <= err_next;
         done_reg     <= done_next;
         busy_reg     <= busy_next;
`ifdef ALU_SEQ_CTRL_MUL_EN
         mplier_reg   <= mplier_next;
         mul_cnt_reg  <= mul_cnt_next;
         ovf_reg      <= ovf_next;
`endif
      end
   end

   assign bus.o_alu_a       = alu_a_reg;
   assign bus.o_alu_b       = alu_b_reg;
   assign bus.o_alu_control = alu_ctrl_reg;
   assign bus.o_busy        = busy_reg;
   assign bus.o_done        = done_reg;
   assign bus.o_q           = q_reg;
   assign bus.o_mayor       = mayor_reg;
   assign bus.o_paridad     = paridad_reg;
   assign bus.o_err         = err_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl wired to the datapath ALU.
// Table-driven command vectors plus hand-written sequences for reset,
// ignored start while busy and reset in the middle of a long command.
// Expected values follow the ALU_SEQ_CTRL_MUL_EN build setting.
module tb_alu_seq_ctrl;
   import alu_pkg::*;

   logic i_clk = 1'b0;
   logic i_reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   alu_seq_ctrl_if #(.N(16)) bus ();

   alu_seq_ctrl #(.N(16)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   alu #(.N(16)) u_alu (
      .a       (bus.o_alu_a),
      .b       (bus.o_alu_b),
      .control (bus.o_alu_control),
      .q       (bus.i_alu_q),
      .mayor   (bus.i_alu_mayor),
      .paridad (bus.i_alu_paridad)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic        mayor;
      logic        paridad;
      logic        err;
      int          lat;    // negedges from start edge to o_done
      logic [3:0]  cmask;  // one-hot ALU control expected while busy, 0 = skip
   } vec_t;

   vec_t vecs[20];
   int   nv = 0;

   task automatic add_vec(input logic [2:0] op, input logic [15:0] a, b, q,
                          input logic m, p, e, input int lat, input logic [3:0] cmask);
      vecs[nv] = '{op, a, b, q, m, p, e, lat, cmask};
      nv++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, b,
                          output int lat, output int ndone, output logic [3:0] seen);
      @(negedge i_clk);
      bus.i_start = 1'b1;
      bus.i_op    = op;
      bus.i_a     = a;
      bus.i_b     = b;
      @(posedge i_clk);
      #1 bus.i_start = 1'b0;
      lat   = -1;
      ndone = 0;
      seen  = '0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge i_clk);
         if (bus.o_busy) seen[bus.o_alu_control] = 1'b1;
         if (bus.o_done) begin
            ndone++;
            if (lat < 0) lat = n;
         end
         if (lat >= 0 && !bus.o_busy) break;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, ndone, cnt;
      logic [3:0] seen;
      logic [15:0] exp_q;

      bus.i_start = 1'b0;
      bus.i_op    = '0;
      bus.i_a     = '0;
      bus.i_b     = '0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      @(negedge i_clk);
      chk("rst_busy",  32'(bus.o_busy), 0);
      chk("rst_done",  32'(bus.o_done), 0);
      chk("rst_q",     32'(bus.o_q), 0);
      chk("rst_mayor", 32'(bus.o_mayor), 0);
      chk("rst_par",   32'(bus.o_paridad), 0);
      chk("rst_err",   32'(bus.o_err), 0);
      chk("rst_alu_a", 32'(bus.o_alu_a), 0);
      chk("rst_alu_b", 32'(bus.o_alu_b), 0);
      chk("rst_ctrl",  32'(bus.o_alu_control), 0);

      //        op       a        b        q        m     p     e     lat cmask
      add_vec(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 2, 4'b0001);
      add_vec(OP_SUB,  16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0, 2, 4'b0100);
      add_vec(OP_SHR1, 16'h0003, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0, 2, 4'b0010);
      add_vec(OP_PASS, 16'h1234, 16'h5555, 16'h1234, 1'b0, 1'b0, 1'b0, 2, 4'b1000);
      add_vec(3'b110,  16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 4'b0000);
      add_vec(OP_ADD,  16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b1, 1'b0, 2, 4'b0001);
      add_vec(OP_SHRN, 16'h8001, 16'h0003, 16'h1000, 1'b0, 1'b0, 1'b0, 4, 4'b0010);
      add_vec(OP_SHRN, 16'h8001, 16'h0000, 16'h8001, 1'b0, 1'b1, 1'b0, 2, 4'b1000);
      add_vec(OP_SHRN, 16'hF0F0, 16'h0014, 16'h0F0F, 1'b0, 1'b1, 1'b0, 5, 4'b0010);
      add_vec(3'b111,  16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 4'b0000);
`ifdef ALU_SEQ_CTRL_MUL_EN
      add_vec(OP_MUL,  16'h0012, 16'h000A, 16'h00B4, 1'b0, 1'b0, 1'b0, 5, 4'b0001);
      add_vec(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0, 10, 4'b0001);
      add_vec(OP_MUL,  16'h0007, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2, 4'b0001);
      add_vec(OP_MUL,  16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b1, 1'b0, 4, 4'b0001);
`else
      add_vec(OP_MUL,  16'h0012, 16'h000A, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 4'b0000);
      add_vec(OP_ADD,  16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0, 2, 4'b0001);
      add_vec(OP_MUL,  16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b1, 1, 4'b0000);
`endif

      for (int i = 0; i < nv; i++) begin
         run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, lat, ndone, seen);
         $display("vec %0d: op=%b a=%h b=%h -> q=%h mayor=%b par=%b err=%b lat=%0d",
                  i, vecs[i].op, vecs[i].a, vecs[i].b, bus.o_q, bus.o_mayor,
                  bus.o_paridad, bus.o_err, lat);
         chk($sformatf("v%0d_q", i),      32'(bus.o_q),       32'(vecs[i].q));
         chk($sformatf("v%0d_mayor", i),  32'(bus.o_mayor),   32'(vecs[i].mayor));
         chk($sformatf("v%0d_par", i),    32'(bus.o_paridad), 32'(vecs[i].paridad));
         chk($sformatf("v%0d_err", i),    32'(bus.o_err),     32'(vecs[i].err));
         chk($sformatf("v%0d_lat", i),    32'(lat),           32'(vecs[i].lat));
         chk($sformatf("v%0d_ndone", i),  32'(ndone),         1);
         if (vecs[i].cmask != 4'b0000)
            chk($sformatf("v%0d_ctrl", i), 32'(seen), 32'(vecs[i].cmask));
         @(negedge i_clk);
         chk($sformatf("v%0d_hold", i),   32'(bus.o_q),       32'(vecs[i].q));
      end

      // Start pulsed while a long command is running must be ignored.
      @(negedge i_clk);
      bus.i_start = 1'b1;
`ifdef ALU_SEQ_CTRL_MUL_EN
      bus.i_op = OP_MUL;  bus.i_a = 16'h0012; bus.i_b = 16'h000A; exp_q = 16'h00B4;
`else
      bus.i_op = OP_SHRN; bus.i_a = 16'h8001; bus.i_b = 16'h0005; exp_q = 16'h0400;
`endif
      @(negedge i_clk);
      bus.i_start = 1'b0;
      @(negedge i_clk);
      bus.i_start = 1'b1;
      bus.i_op = OP_ADD; bus.i_a = 16'h0001; bus.i_b = 16'h0001;
      @(negedge i_clk);
      bus.i_start = 1'b0;
      cnt = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge i_clk);
         if (bus.o_done) cnt++;
      end
      $display("busy-start: done pulses=%0d q=%h", cnt, bus.o_q);
      chk("busy_start_ndone", 32'(cnt), 1);
      chk("busy_start_q", 32'(bus.o_q), 32'(exp_q));

      // Reset in the middle of a long command aborts it.
      @(negedge i_clk);
      bus.i_start = 1'b1;
`ifdef ALU_SEQ_CTRL_MUL_EN
      bus.i_op = OP_MUL;  bus.i_a = 16'h0100; bus.i_b = 16'h0100;
`else
      bus.i_op = OP_SHRN; bus.i_a = 16'hFFFF; bus.i_b = 16'h000F;
`endif
      @(negedge i_clk);
      bus.i_start = 1'b0;
      repeat (3) @(negedge i_clk);
      chk("mid_busy_before", 32'(bus.o_busy), 1);
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      chk("mid_rst_busy",  32'(bus.o_busy), 0);
      chk("mid_rst_q",     32'(bus.o_q), 0);
      chk("mid_rst_mayor", 32'(bus.o_mayor), 0);
      chk("mid_rst_par",   32'(bus.o_paridad), 0);
      chk("mid_rst_err",   32'(bus.o_err), 0);
      chk("mid_rst_alu_a", 32'(bus.o_alu_a), 0);
      chk("mid_rst_alu_b", 32'(bus.o_alu_b), 0);
      chk("mid_rst_ctrl",  32'(bus.o_alu_control), 0);
      cnt = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge i_clk);
         if (bus.o_done || bus.o_busy) cnt++;
      end
      $display("mid-reset: activity cycles after reset=%0d", cnt);
      chk("mid_rst_no_done", 32'(cnt), 0);

      // Block accepts a fresh command after the abort.
      run_cmd(OP_SUB, 16'h0010, 16'h0001, lat, ndone, seen);
      $display("post-reset: SUB q=%h lat=%0d", bus.o_q, lat);
      chk("post_rst_q",   32'(bus.o_q), 32'h000F);
      chk("post_rst_lat", 32'(lat), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
